// File: rtl/enc8to3_if.sv
// Request/grant bundle for the registered 8-to-3 priority encoder.
// The master drives requests and the consumer's ready; the slave returns the granted code stream.
interface enc8to3_if;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       ovf;

  modport master (
    output en, req, ready,
    input  code, valid, pending, ovf
  );

  modport slave (
    input  en, req, ready,
    output code, valid, pending, ovf
  );
endinterface

// File: rtl/enc8to3_seq.sv
// Registered 8-to-3 priority encoder: requests accumulate in a pending mask and
// are emitted one index per valid/ready handshake, each served bit cleared.
module enc8to3_seq #(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  enc8to3_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic       ovf_q, ovf_d;

  logic [7:0] arr;
  logic [7:0] cand;
  logic       slot_free;
  logic [2:0] grant_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= 3'd0;
      pending_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Later iterations overwrite earlier ones, so scan direction sets the winning end.
  always_comb begin
    grant_idx = 3'd0;
    if (PRIO_MSB) begin
      for (int i = 0; i < 8; i++)
        if (cand[i]) grant_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (cand[i]) grant_idx = 3'(i);
    end
  end

  always_comb begin
    arr       = bus.en ? bus.req : 8'h00;
    cand      = pending_q | arr;
    slot_free = (state_q == IDLE) || bus.ready;
    state_d   = state_q;
    code_d    = code_q;
    pending_d = cand;
    ovf_d     = ovf_q | (|(arr & pending_q));
    if (slot_free) begin
      if (cand != 8'h00) begin
        // A bit arriving on its own grant edge is cleared here, not re-queued.
        state_d   = HOLD;
        code_d    = grant_idx;
        pending_d = cand & ~(8'h01 << grant_idx);
      end else begin
        state_d   = IDLE;
        pending_d = 8'h00;
      end
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = (state_q == HOLD);
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: MSB- and LSB-priority instances share stimulus and are
// compared each cycle against a mask-level reference model.
module tb_enc8to3_seq;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  enc8to3_if if_msb ();
  enc8to3_if if_lsb ();

  enc8to3_seq #(.PRIO_MSB(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(if_msb));
  enc8to3_seq #(.PRIO_MSB(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(if_lsb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state per instance: 0 = MSB priority, 1 = LSB priority.
  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];
  logic       m_ovf   [2];

  function automatic int pick(input bit msb_first, input logic [7:0] m);
    if (msb_first) begin
      for (int i = 7; i >= 0; i--) if (m[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step(input int u, input bit msb_first, input bit r,
                            input bit e, input logic [7:0] q, input bit rdy);
    logic [7:0] arrivals;
    logic [7:0] queue;
    int g;
    if (r) begin
      m_pend[u] = 8'h00; m_valid[u] = 1'b0; m_code[u] = 3'd0; m_ovf[u] = 1'b0;
      return;
    end
    arrivals = e ? q : 8'h00;
    if ((arrivals & m_pend[u]) != 8'h00) m_ovf[u] = 1'b1;
    queue = m_pend[u] | arrivals;
    if (m_valid[u] && !rdy) begin
      m_pend[u] = queue;
    end else if (queue == 8'h00) begin
      m_valid[u] = 1'b0;
      m_pend[u]  = 8'h00;
    end else begin
      g = pick(msb_first, queue);
      m_code[u]  = 3'(g);
      m_valid[u] = 1'b1;
      m_pend[u]  = queue - 8'(1 << g);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("msb_code",    {5'd0, if_msb.code},    {5'd0, m_code[0]});
    check("msb_valid",   {7'd0, if_msb.valid},   {7'd0, m_valid[0]});
    check("msb_pending", if_msb.pending,         m_pend[0]);
    check("msb_ovf",     {7'd0, if_msb.ovf},     {7'd0, m_ovf[0]});
    check("lsb_code",    {5'd0, if_lsb.code},    {5'd0, m_code[1]});
    check("lsb_valid",   {7'd0, if_lsb.valid},   {7'd0, m_valid[1]});
    check("lsb_pending", if_lsb.pending,         m_pend[1]);
    check("lsb_ovf",     {7'd0, if_lsb.ovf},     {7'd0, m_ovf[1]});
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] q, input bit rdy);
    @(negedge clk);
    rst = r;
    if_msb.en = e; if_msb.req = q; if_msb.ready = rdy;
    if_lsb.en = e; if_lsb.req = q; if_lsb.ready = rdy;
    @(posedge clk);
    model_step(0, 1'b1, r, e, q, rdy);
    model_step(1, 1'b0, r, e, q, rdy);
    #1;
    checkOutput();
  endtask

  // Directed spot check of a (code, valid, pending) triple against literal values.
  task automatic expect_state(input string tag, input bit use_lsb, input logic [2:0] c,
                              input bit v, input logic [7:0] p);
    if (use_lsb) begin
      if (v) check({tag, "_code"}, {5'd0, if_lsb.code}, {5'd0, c});
      check({tag, "_valid"}, {7'd0, if_lsb.valid}, {7'd0, v});
      check({tag, "_pend"},  if_lsb.pending, p);
    end else begin
      if (v) check({tag, "_code"}, {5'd0, if_msb.code}, {5'd0, c});
      check({tag, "_valid"}, {7'd0, if_msb.valid}, {7'd0, v});
      check({tag, "_pend"},  if_msb.pending, p);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1;
    if_msb.en = 1'b0; if_msb.req = 8'h00; if_msb.ready = 1'b0;
    if_lsb.en = 1'b0; if_lsb.req = 8'h00; if_lsb.ready = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 8'h00; m_valid[u] = 1'b0; m_code[u] = 3'd0; m_ovf[u] = 1'b0;
    end

    // Reset state
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    expect_state("reset", 1'b0, 3'd0, 1'b0, 8'h00);
    check("reset_code", {5'd0, if_msb.code}, 8'h00);
    check("reset_ovf", {7'd0, if_msb.ovf}, 8'h00);

    // Single request, one-cycle latency
    applyStimulus(1'b0, 1'b1, 8'h08, 1'b1);
    expect_state("t1_grant", 1'b0, 3'd3, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t1_idle", 1'b0, 3'd0, 1'b0, 8'h00);

    // Multi-hot burst served in priority order on both ends
    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b1);
    expect_state("t2_g0_msb", 1'b0, 3'd7, 1'b1, 8'h21);
    expect_state("t2_g0_lsb", 1'b1, 3'd0, 1'b1, 8'hA0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t2_g1_msb", 1'b0, 3'd5, 1'b1, 8'h01);
    expect_state("t2_g1_lsb", 1'b1, 3'd5, 1'b1, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t2_g2_msb", 1'b0, 3'd0, 1'b1, 8'h00);
    expect_state("t2_g2_lsb", 1'b1, 3'd7, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t2_done", 1'b0, 3'd0, 1'b0, 8'h00);

    // Held code is not replaced while the consumer stalls
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
    expect_state("t3_hold", 1'b0, 3'd4, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h80, 1'b0);
    expect_state("t3_stall", 1'b0, 3'd4, 1'b1, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t3_next", 1'b0, 3'd7, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);

    // Disabled sampling ignores req entirely
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1);
      expect_state("t4_en0", 1'b0, 3'd0, 1'b0, 8'h00);
      check("t4_ovf", {7'd0, if_msb.ovf}, 8'h00);
    end

    // Duplicate on a pending bit sets sticky ovf and is merged
    applyStimulus(1'b0, 1'b1, 8'h20, 1'b0);
    expect_state("t5_hold5", 1'b0, 3'd5, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    expect_state("t5_dup", 1'b0, 3'd5, 1'b1, 8'h02);
    check("t5_ovf_set", {7'd0, if_msb.ovf}, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t5_one", 1'b0, 3'd1, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    expect_state("t5_drained", 1'b0, 3'd0, 1'b0, 8'h00);
    check("t5_ovf_sticky", {7'd0, if_msb.ovf}, 8'h01);

    // Reset mid-handshake drops everything
    applyStimulus(1'b0, 1'b1, 8'h20, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 1'b0);
    expect_state("t6_pre", 1'b0, 3'd5, 1'b1, 8'h0C);
    applyStimulus(1'b1, 1'b1, 8'h0C, 1'b0);
    expect_state("t6_rst", 1'b0, 3'd0, 1'b0, 8'h00);
    check("t6_code", {5'd0, if_msb.code}, 8'h00);
    check("t6_ovf", {7'd0, if_msb.ovf}, 8'h00);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] q;
      q = 8'($urandom) & 8'($urandom);
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), q,
                    ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
